// File: rtl/e_mdu_pkg.sv
// Shared MDU definitions: operation encodings, default latencies and small helpers.
package cpu_defs;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MFHI  = 3'd4,
    OP_MFLO  = 3'd5,
    OP_MTHI  = 3'd6,
    OP_MTLO  = 3'd7
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  localparam int MUL_LAT_DEF = 5;
  localparam int DIV_LAT_DEF = 10;

  // Multi-cycle ops occupy the low half of the encoding space.
  function automatic logic is_long_op(input logic [2:0] op);
    return ~op[2];
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return ~op[2] & op[1];
  endfunction

endpackage

// File: rtl/e_mdu_arith.sv
// Combinational MDU datapath: 64-bit product and signed/unsigned quotient/remainder.
module e_mdu_arith
  import cpu_defs::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  op,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div0
);

  logic signed [63:0] sprod;
  logic        [63:0] uprod;
  logic        [31:0] dvd_mag;
  logic        [31:0] dvs_mag;
  logic        [31:0] uq;
  logic        [31:0] ur;
  logic               is_signed;

  // Magnitude of a two's-complement word; 0x80000000 maps to itself as unsigned.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

  assign sprod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign uprod = {32'd0, a} * {32'd0, b};

  assign is_signed = (op == OP_DIV);
  assign div0      = (b == 32'd0);
  assign dvd_mag   = mag32(a, is_signed);
  assign dvs_mag   = div0 ? 32'd1 : mag32(b, is_signed);
  assign uq        = dvd_mag / dvs_mag;
  assign ur        = dvd_mag % dvs_mag;

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    unique case (op)
      OP_MULT:  {res_hi, res_lo} = sprod;
      OP_MULTU: {res_hi, res_lo} = uprod;
      OP_DIV: begin
        // Quotient truncates toward zero; remainder follows the dividend's sign.
        res_lo = (a[31] ^ b[31]) ? (~uq + 32'd1) : uq;
        res_hi = a[31] ? (~ur + 32'd1) : ur;
      end
      OP_DIVU: begin
        res_lo = uq;
        res_hi = ur;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: owns HI/LO, models op latency with a busy counter.
module e_mdu
  import cpu_defs::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rd
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  mdu_state_e         st;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        a_p0;
  logic [31:0]        b_p0;
  logic [2:0]         op_p0;
  logic [31:0]        res_hi;
  logic [31:0]        res_lo;
  logic               div0;
  logic               accept;

  assign accept = start && (st == ST_IDLE);
  assign busy   = (st == ST_BUSY);

  // Stage p0: operands captured at issue; later a/b changes cannot disturb the result.
  always_ff @(posedge clk) begin
    if (accept && is_long_op(op)) begin
      a_p0  <= a;
      b_p0  <= b;
      op_p0 <= op;
    end
  end

  e_mdu_arith u_arith (
    .a      (a_p0),
    .b      (b_p0),
    .op     (op_p0),
    .res_hi (res_hi),
    .res_lo (res_lo),
    .div0   (div0)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      st  <= ST_IDLE;
      cnt <= '0;
      hi  <= 32'd0;
      lo  <= 32'd0;
    end else begin
      unique case (st)
        ST_IDLE: begin
          if (start) begin
            unique case (op)
              OP_MULT, OP_MULTU: begin
                cnt <= CNT_W'(MUL_LAT);
                st  <= ST_BUSY;
              end
              OP_DIV, OP_DIVU: begin
                cnt <= CNT_W'(DIV_LAT);
                st  <= ST_BUSY;
              end
              OP_MTHI: hi <= a;
              OP_MTLO: lo <= a;
              default: ;
            endcase
          end
        end
        ST_BUSY: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            st <= ST_IDLE;
            // Divide by zero leaves HI/LO as they were.
            if (!(is_div_op(op_p0) && div0)) begin
              hi <= res_hi;
              lo <= res_lo;
            end
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    rd = 32'd0;
    if (op == OP_MFHI) rd = hi;
    else if (op == OP_MFLO) rd = lo;
  end

endmodule

// File: tb/tb_e_mdu.sv
// Scoreboard bench for e_mdu: reference model computes results with plain 64-bit arithmetic.
module tb_e_mdu;
  import cpu_defs::*;

  localparam int ML = 5;
  localparam int DL = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy;
  logic [31:0] hi, lo, rd;

  e_mdu #(.MUL_LAT(ML), .DIV_LAT(DL)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .hi(hi), .lo(lo), .rd(rd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] mhi = 32'd0;
  logic [31:0] mlo = 32'd0;
  int          mcnt = 0;
  logic [63:0] pend;
  bit          rst_fall_ok = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] x,
                                             input logic [31:0] y, input logic [31:0] ch,
                                             input logic [31:0] cl);
    longint          sx, sy, sq, sr;
    longint unsigned ux, uy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (o)
      OP_MULT:  return 64'(sx * sy);
      OP_MULTU: return ux * uy;
      OP_DIV: begin
        if (y == 0) return {ch, cl};
        sq = sx / sy;
        sr = sx % sy;
        return {sr[31:0], sq[31:0]};
      end
      OP_DIVU: begin
        if (y == 0) return {ch, cl};
        return {32'(ux % uy), 32'(ux / uy)};
      end
      default: return {ch, cl};
    endcase
  endfunction

  // Advance the reference model across the clock edge about to happen.
  task automatic model_edge(input logic st, input logic [2:0] o, input logic [31:0] x,
                            input logic [31:0] y, input logic rs);
    if (rs) begin
      if (mcnt != 0) rst_fall_ok = 1'b1;
      sb.delete();
      mhi = 0; mlo = 0; mcnt = 0;
    end else if (mcnt != 0) begin
      mcnt--;
      if (mcnt == 0) {mhi, mlo} = pend;
    end else if (st) begin
      if (o <= 3'd3) begin
        pend = ref_result(o, x, y, mhi, mlo);
        mcnt = (o <= 3'd1) ? ML : DL;
        sb.push_back('{hi: pend[63:32], lo: pend[31:0], lat: mcnt});
      end else if (o == OP_MTHI) mhi = x;
      else if (o == OP_MTLO) mlo = x;
    end
  endtask

  task automatic cyc(input logic st, input logic [2:0] o, input logic [31:0] x,
                     input logic [31:0] y, input logic rs = 1'b0);
    logic [31:0] exp_rd;
    @(posedge clk);
    #1;
    start = st; op = o; a = x; b = y; reset = rs;
    #1;
    exp_rd = (o == OP_MFHI) ? mhi : (o == OP_MFLO) ? mlo : 32'd0;
    chk("busy", 64'(busy), 64'(mcnt != 0));
    chk("hi", 64'(hi), 64'(mhi));
    chk("lo", 64'(lo), 64'(mlo));
    chk("rd", 64'(rd), 64'(exp_rd));
    model_edge(st, o, x, y, rs);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, OP_MULT, $urandom, $urandom);
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 32'($signed($urandom_range(0, 40)) - 20);
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd0;
      default: return $urandom;
    endcase
  endfunction

  // Completion monitor: every busy fall must match the next queued result.
  int run = 0;
  bit prev_busy = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (busy === 1'b1) run++;
    else if (prev_busy) begin
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("done_lat", 64'(run), 64'(e.lat));
        chk("done_hi", 64'(hi), 64'(e.hi));
        chk("done_lo", 64'(lo), 64'(e.lo));
      end else if (rst_fall_ok) begin
        rst_fall_ok = 1'b0;
      end else begin
        checks++;
        errors++;
        $display("FAIL done_unexpected actual=busy_fall required=no_pending_op at %0t", $time);
      end
      run = 0;
    end
    prev_busy = (busy === 1'b1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; op = OP_MULT; a = 0; b = 0;
    repeat (3) @(posedge clk);

    // MULT -2 x 3
    cyc(1, OP_MULT, 32'hFFFF_FFFE, 32'd3);
    idle(ML);
    cyc(0, OP_MFHI, 0, 0);
    chk("t1_hi", 64'(hi), 64'hFFFF_FFFF);
    chk("t1_lo", 64'(lo), 64'hFFFF_FFFA);

    // MULTU 0xFFFFFFFF x 2
    cyc(1, OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    idle(ML);
    cyc(0, OP_MFLO, 0, 0);
    chk("t2_hi", 64'(hi), 64'h1);
    chk("t2_lo", 64'(lo), 64'hFFFF_FFFE);

    // DIV -7 / 2
    cyc(1, OP_DIV, 32'hFFFF_FFF9, 32'd2);
    idle(DL);
    cyc(0, OP_MFLO, 0, 0);
    chk("t3_hi", 64'(hi), 64'hFFFF_FFFF);
    chk("t3_lo", 64'(lo), 64'hFFFF_FFFD);

    // DIV overflow case
    cyc(1, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    idle(DL);
    cyc(0, OP_MFLO, 0, 0);
    chk("ovf_hi", 64'(hi), 64'h0);
    chk("ovf_lo", 64'(lo), 64'h8000_0000);

    // DIVU by zero keeps HI/LO
    cyc(1, OP_MTHI, 32'h1234, 0);
    cyc(1, OP_MTLO, 32'h5678, 0);
    cyc(1, OP_DIVU, 32'd99, 32'd0);
    idle(DL);
    cyc(0, OP_MFHI, 0, 0);
    chk("t4_rd", 64'(rd), 64'h1234);
    chk("t4_lo", 64'(lo), 64'h5678);

    // DIV, MTLO while busy, then reset mid-operation
    cyc(1, OP_DIV, 32'd100, 32'd7);
    idle(2);
    cyc(1, OP_MTLO, 32'hAAAA, 0);
    idle(2);
    cyc(0, OP_MULT, 0, 0, 1'b1);
    cyc(0, OP_MFLO, 0, 0);
    chk("t5_busy", 64'(busy), 64'h0);
    chk("t5_hi", 64'(hi), 64'h0);
    chk("t5_lo", 64'(lo), 64'h0);
    idle(DL);
    chk("t5_late_lo", 64'(lo), 64'h0);

    // MULT 7 x 6 with a/b churning, then back-to-back MULT
    cyc(1, OP_MULT, 32'd7, 32'd6);
    for (int i = 0; i < ML; i++) cyc(0, 3'($urandom_range(0, 7)), $urandom, $urandom);
    cyc(1, OP_MULT, 32'd3, 32'd5);
    chk("t6_hi", 64'(hi), 64'h0);
    chk("t6_lo", 64'(lo), 64'd42);
    idle(1);
    chk("t6_busy", 64'(busy), 64'h1);
    idle(ML);

    // Random mix including ignored starts and occasional reset
    for (int i = 0; i < 600; i++)
      cyc(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), rnd_val(), rnd_val(),
          ($urandom_range(0, 149) == 0));
    idle(DL + 2);
    chk("sb_drained", 64'(sb.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
